// File: rtl/fp_divider_iter.sv
// Iterative IEEE-754 divider: radix-2 restoring mantissa division, RNE rounding, flush-to-zero.
// Optional exception flags output enabled with `define FPDIV_FLAGS_EN.
module fp_divider_iter #(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52
) (
    input  logic                   clk,
    input  logic                   rset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   dividend,
    input  logic [EXP_W+MAN_W:0]   divisor,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   quotient
`ifdef FPDIV_FLAGS_EN
    ,
    output logic [4:0]             flags
`endif
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int EW2   = EXP_W + 2;
    localparam int CNT_W = $clog2(MAN_W + 3);
    localparam logic signed [EW2-1:0] E_BIAS = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW2-1:0] E_INF  = EW2'((1 << EXP_W) - 1);
    localparam logic signed [EW2-1:0] E_ONE  = EW2'(1);
    localparam logic signed [EW2-1:0] E_ZERO = EW2'(0);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(MAN_W + 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_DIVIDE = 3'd2,
        S_NORM   = 3'd3,
        S_ROUND  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                 state_r;
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic [W-1:0]           quotient_r;
    logic [W-1:0]           a_r;
    logic [W-1:0]           b_r;
    logic                   sign_r;
    logic signed [EW2-1:0]  exp_r;
    logic [MAN_W+2:0]       quo_r;
    logic [MAN_W+1:0]       rem_r;
    logic [MAN_W:0]         mb_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [MAN_W-1:0]       frac_r;
    logic                   guard_r;
    logic                   sticky_r;

    logic [EXP_W-1:0]       ea_s;
    logic [EXP_W-1:0]       eb_s;
    logic [MAN_W-1:0]       fa_s;
    logic [MAN_W-1:0]       fb_s;
    logic                   a_nan_s;
    logic                   b_nan_s;
    logic                   a_inf_s;
    logic                   b_inf_s;
    logic                   a_zero_s;
    logic                   b_zero_s;
    logic                   sign_s;
    logic                   spec_hit_s;
    logic [W-1:0]           spec_res_s;
    logic                   ge_s;
    logic [MAN_W:0]         diff_s;
    logic                   inc_s;
    logic                   carry_s;
    logic [MAN_W-1:0]       frac_rnd_s;
    logic signed [EW2-1:0]  exp_rnd_s;
    logic                   ovf_s;
    logic                   unf_s;
    logic [W-1:0]           rnd_res_s;

    // Field extraction and operand classification; subnormal operands count as zero.
    always_comb begin
        ea_s     = a_r[W-2:MAN_W];
        eb_s     = b_r[W-2:MAN_W];
        fa_s     = a_r[MAN_W-1:0];
        fb_s     = b_r[MAN_W-1:0];
        a_nan_s  = (&ea_s) & (|fa_s);
        b_nan_s  = (&eb_s) & (|fb_s);
        a_inf_s  = (&ea_s) & ~(|fa_s);
        b_inf_s  = (&eb_s) & ~(|fb_s);
        a_zero_s = (ea_s == {EXP_W{1'b0}});
        b_zero_s = (eb_s == {EXP_W{1'b0}});
        sign_s   = a_r[W-1] ^ b_r[W-1];
    end

    // Special-case result, priority ordered (NaN class first).
    always_comb begin
        spec_hit_s = 1'b1;
        spec_res_s = {W{1'b0}};
        if (a_nan_s | b_nan_s | (a_zero_s & b_zero_s) | (a_inf_s & b_inf_s)) begin
            spec_res_s = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        end else if (b_zero_s | a_inf_s) begin
            spec_res_s = {sign_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf_s | a_zero_s) begin
            spec_res_s = {sign_s, {(W-1){1'b0}}};
        end else begin
            spec_hit_s = 1'b0;
        end
    end

    // One restoring-division step; rem_r never exceeds 2*mb so the low bits hold the difference.
    always_comb begin
        ge_s   = (rem_r >= {1'b0, mb_r});
        diff_s = rem_r[MAN_W:0] - mb_r;
    end

    // Round-to-nearest-even plus overflow / flush-to-zero selection.
    always_comb begin
        inc_s                 = guard_r & (sticky_r | frac_r[0]);
        {carry_s, frac_rnd_s} = {1'b0, frac_r} + {{MAN_W{1'b0}}, inc_s};
        if (carry_s) begin
            exp_rnd_s = exp_r + E_ONE;
        end else begin
            exp_rnd_s = exp_r;
        end
        ovf_s = (exp_rnd_s >= E_INF);
        unf_s = (exp_rnd_s <= E_ZERO);
        if (ovf_s) begin
            rnd_res_s = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (unf_s) begin
            rnd_res_s = {sign_r, {(W-1){1'b0}}};
        end else begin
            rnd_res_s = {sign_r, exp_rnd_s[EXP_W-1:0], frac_rnd_s};
        end
    end

`ifdef FPDIV_FLAGS_EN
    logic [4:0] spec_flags_s;
    logic [4:0] rnd_flags_s;
    logic [4:0] flags_r;
    logic       a_snan_s;
    logic       b_snan_s;

    // Exception flags {invalid, div_by_zero, overflow, underflow, inexact} for both result paths.
    always_comb begin
        a_snan_s     = a_nan_s & ~fa_s[MAN_W-1];
        b_snan_s     = b_nan_s & ~fb_s[MAN_W-1];
        spec_flags_s = 5'b00000;
        if (a_nan_s | b_nan_s | (a_zero_s & b_zero_s) | (a_inf_s & b_inf_s)) begin
            spec_flags_s[4] = a_snan_s | b_snan_s | (a_zero_s & b_zero_s) | (a_inf_s & b_inf_s);
        end else if (b_zero_s & ~a_inf_s) begin
            spec_flags_s[3] = 1'b1;
        end else begin
            spec_flags_s = 5'b00000;
        end
        rnd_flags_s = {2'b00, ovf_s, unf_s, guard_r | sticky_r | ovf_s | unf_s};
    end

    assign flags = flags_r;
`endif

    // Control FSM with the datapath and handshake registers.
    always_ff @(posedge clk) begin
        if (!rset) begin
            state_r     <= S_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            quotient_r  <= {W{1'b0}};
            a_r         <= {W{1'b0}};
            b_r         <= {W{1'b0}};
            sign_r      <= 1'b0;
            exp_r       <= E_ZERO;
            quo_r       <= {(MAN_W+3){1'b0}};
            rem_r       <= {(MAN_W+2){1'b0}};
            mb_r        <= {(MAN_W+1){1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            frac_r      <= {MAN_W{1'b0}};
            guard_r     <= 1'b0;
            sticky_r    <= 1'b0;
`ifdef FPDIV_FLAGS_EN
            flags_r     <= 5'b00000;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        a_r        <= dividend;
                        b_r        <= divisor;
                        in_ready_r <= 1'b0;
                        state_r    <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    sign_r <= sign_s;
                    exp_r  <= $signed({2'b00, ea_s}) - $signed({2'b00, eb_s}) + E_BIAS;
                    rem_r  <= {1'b0, 1'b1, fa_s};
                    mb_r   <= {1'b1, fb_s};
                    quo_r  <= {(MAN_W+3){1'b0}};
                    cnt_r  <= {CNT_W{1'b0}};
                    if (spec_hit_s) begin
                        quotient_r <= spec_res_s;
`ifdef FPDIV_FLAGS_EN
                        flags_r    <= spec_flags_s;
`endif
                        state_r    <= S_DONE;
                    end else begin
                        state_r    <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    if (ge_s) begin
                        quo_r <= {quo_r[MAN_W+1:0], 1'b1};
                        rem_r <= {diff_s, 1'b0};
                    end else begin
                        quo_r <= {quo_r[MAN_W+1:0], 1'b0};
                        rem_r <= {rem_r[MAN_W:0], 1'b0};
                    end
                    if (cnt_r == CNT_LAST) begin
                        state_r <= S_NORM;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                S_NORM: begin
                    if (quo_r[MAN_W+2]) begin
                        frac_r   <= quo_r[MAN_W+1:2];
                        guard_r  <= quo_r[1];
                        sticky_r <= quo_r[0] | (|rem_r);
                    end else begin
                        frac_r   <= quo_r[MAN_W:1];
                        guard_r  <= quo_r[0];
                        sticky_r <= |rem_r;
                        exp_r    <= exp_r - E_ONE;
                    end
                    state_r <= S_ROUND;
                end
                S_ROUND: begin
                    quotient_r <= rnd_res_s;
`ifdef FPDIV_FLAGS_EN
                    flags_r    <= rnd_flags_s;
`endif
                    state_r    <= S_DONE;
                end
                S_DONE: begin
                    // out_valid rises one cycle after entering DONE, giving the fixed latencies.
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= S_IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign quotient  = quotient_r;

endmodule

// File: tb/tb_fp_divider_iter.sv
// Randomised self-checking bench for fp_divider_iter (double and single precision instances)
// against a wide-integer reference model of the IEEE divide with RNE and flush-to-zero.
module tb_fp_divider_iter;
    logic        clk = 1'b0;
    logic        rset;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic [63:0] quotient;
    logic        sp_in_valid;
    logic        sp_in_ready;
    logic        sp_out_valid;
    logic        sp_out_ready;
    logic [31:0] sp_dividend;
    logic [31:0] sp_divisor;
    logic [31:0] sp_quotient;
`ifdef FPDIV_FLAGS_EN
    logic [4:0]  flags;
    logic [4:0]  sp_flags;
`endif
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fp_divider_iter dut (
        .clk       (clk),
        .rset      (rset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient)
`ifdef FPDIV_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    fp_divider_iter #(.EXP_W(8), .MAN_W(23)) dut_sp (
        .clk       (clk),
        .rset      (rset),
        .in_valid  (sp_in_valid),
        .in_ready  (sp_in_ready),
        .dividend  (sp_dividend),
        .divisor   (sp_divisor),
        .out_valid (sp_out_valid),
        .out_ready (sp_out_ready),
        .quotient  (sp_quotient)
`ifdef FPDIV_FLAGS_EN
        ,
        .flags     (sp_flags)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Returns {special_path, flags[4:0], result[63:0]} for format (ew, mw).
    function automatic logic [69:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                            input int ew, input int mw);
        longint      emax, bias, ea, eb, e;
        logic [63:0] fmask, fa, fb, inf_v, zero_v, nan_v;
        logic        s, an, bn, ai, bi, az, bz, a_sig, b_sig, up, inexact;
        logic [127:0] num, den, q, r, low, half, keep;
        int          d;
        emax   = (longint'(1) << ew) - 64'sd1;
        bias   = (longint'(1) << (ew - 1)) - 64'sd1;
        fmask  = (64'd1 << mw) - 64'd1;
        fa     = a & fmask;
        fb     = b & fmask;
        ea     = longint'((a >> mw) & 64'(emax));
        eb     = longint'((b >> mw) & 64'(emax));
        s      = a[ew+mw] ^ b[ew+mw];
        an     = (ea == emax) && (fa != 64'd0);
        bn     = (eb == emax) && (fb != 64'd0);
        ai     = (ea == emax) && (fa == 64'd0);
        bi     = (eb == emax) && (fb == 64'd0);
        az     = (ea == 64'sd0);
        bz     = (eb == 64'sd0);
        a_sig  = an && !a[mw-1];
        b_sig  = bn && !b[mw-1];
        inf_v  = (64'(s) << (ew + mw)) | (64'(emax) << mw);
        zero_v = 64'(s) << (ew + mw);
        nan_v  = (64'(emax) << mw) | (64'd1 << (mw - 1));
        if (an || bn || (az && bz) || (ai && bi))
            return {1'b1, (a_sig || b_sig || (az && bz) || (ai && bi)), 4'b0000, nan_v};
        if (bz) return {1'b1, 1'b0, !ai, 3'b000, inf_v};
        if (ai) return {1'b1, 5'b00000, inf_v};
        if (bi || az) return {1'b1, 5'b00000, zero_v};
        num  = 128'(fa | (64'd1 << mw)) << (mw + 2);
        den  = 128'(fb | (64'd1 << mw));
        q    = num / den;
        r    = num % den;
        e    = ea - eb + bias;
        if ((q >> (mw + 2)) != 128'd0) begin
            d = 2;
        end else begin
            d = 1;
            e = e - 64'sd1;
        end
        keep    = q >> d;
        low     = q & ((128'd1 << d) - 128'd1);
        half    = 128'd1 << (d - 1);
        up      = (low > half) || ((low == half) && ((r != 128'd0) || keep[0]));
        inexact = (low != 128'd0) || (r != 128'd0);
        keep    = keep + 128'(up);
        if ((keep >> (mw + 1)) != 128'd0) begin
            keep = keep >> 1;
            e    = e + 64'sd1;
        end
        if (e >= emax) return {1'b0, 5'b00101, inf_v};
        if (e <= 64'sd0) return {1'b0, 5'b00011, zero_v};
        return {1'b0, 4'b0000, inexact, (64'(s) << (ew + mw)) | (64'(e) << mw) | (keep[63:0] & fmask)};
    endfunction

    function automatic logic [63:0] rand_dp();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 11))
            0:       v[62:0]  = 63'd0;
            1:       v[62:52] = 11'h7FF;
            2:       v[62:52] = 11'h000;
            3:       v[62:52] = 11'h7FF;
            4, 5, 6: v[62:52] = 11'(1020 + $urandom_range(0, 7));
            default: v[63]    = v[63];
        endcase
        return v;
    endfunction

    task automatic run_dp(input logic [63:0] a, input logic [63:0] b, input int hold,
                          input logic want_en, input logic [63:0] want);
        logic [69:0] m;
        int          cyc;
        m   = ref_div(a, b, 11, 52);
        cyc = 0;
        while (!in_ready && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc      = 0;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("dp_latency", 64'(cyc), m[69] ? 64'd2 : 64'd59);
        check("dp_quotient", quotient, m[63:0]);
        if (want_en) check("dp_known", quotient, want);
`ifdef FPDIV_FLAGS_EN
        check("dp_flags", 64'(flags), 64'(m[68:64]));
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_quotient", quotient, m[63:0]);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_out_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("dp_post_valid", 64'(out_valid), 64'd0);
        check("dp_post_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic run_sp(input logic [31:0] a, input logic [31:0] b,
                          input logic want_en, input logic [31:0] want);
        logic [69:0] m;
        int          cyc;
        m           = ref_div({32'd0, a}, {32'd0, b}, 8, 23);
        sp_dividend = a;
        sp_divisor  = b;
        sp_in_valid = 1'b1;
        @(posedge clk); #1;
        sp_in_valid = 1'b0;
        cyc         = 0;
        while (!sp_out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("sp_latency", 64'(cyc), m[69] ? 64'd2 : 64'd30);
        check("sp_quotient", 64'(sp_quotient), m[63:0]);
        if (want_en) check("sp_known", 64'(sp_quotient), 64'(want));
`ifdef FPDIV_FLAGS_EN
        check("sp_flags", 64'(sp_flags), 64'(m[68:64]));
`endif
        sp_out_ready = 1'b1;
        @(posedge clk); #1;
        sp_out_ready = 1'b0;
        check("sp_post_in_ready", 64'(sp_in_ready), 64'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rset         = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        dividend     = 64'd0;
        divisor      = 64'd0;
        sp_in_valid  = 1'b0;
        sp_out_ready = 1'b0;
        sp_dividend  = 32'd0;
        sp_divisor   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_quotient", quotient, 64'd0);
        check("rst_sp_in_ready", 64'(sp_in_ready), 64'd1);
        rset = 1'b1;
        @(posedge clk); #1;

        run_dp(64'h4018000000000000, 64'h4000000000000000, 0, 1'b1, 64'h4008000000000000);
        run_dp(64'h3FF0000000000000, 64'h4008000000000000, 0, 1'b1, 64'h3FD5555555555555);
        run_dp(64'h3FF0000000000000, 64'h0000000000000000, 0, 1'b1, 64'h7FF0000000000000);
        run_dp(64'hBFF0000000000000, 64'h0000000000000000, 0, 1'b1, 64'hFFF0000000000000);
        run_dp(64'h0000000000000000, 64'h0000000000000000, 0, 1'b1, 64'h7FF8000000000000);
        run_dp(64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 10, 1'b1, 64'h7FF0000000000000);
        run_dp(64'h0010000000000000, 64'h4000000000000000, 0, 1'b1, 64'h0000000000000000);
        run_dp(64'h7FF0000000000000, 64'hFFF0000000000000, 0, 1'b1, 64'h7FF8000000000000);
        run_dp(64'h7FF4000000000000, 64'h3FF0000000000000, 0, 1'b1, 64'h7FF8000000000000);

        // Abort mid-divide with a one-edge reset.
        dividend = 64'h4018000000000000;
        divisor  = 64'h4000000000000000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rset = 1'b0;
        @(posedge clk); #1;
        rset = 1'b1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_quotient", quotient, 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (70) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_result", 64'(seen), 64'd0);
        run_dp(64'h4018000000000000, 64'h4000000000000000, 0, 1'b1, 64'h4008000000000000);

        for (int i = 0; i < 40; i++) begin
            run_dp(rand_dp(), rand_dp(), (i % 8 == 3) ? 3 : 0, 1'b0, 64'd0);
        end

        run_sp(32'h3F800000, 32'h40400000, 1'b1, 32'h3EAAAAAB);
        run_sp(32'h3F800000, 32'h00000000, 1'b1, 32'h7F800000);
        for (int i = 0; i < 12; i++) begin
            run_sp($urandom, $urandom, 1'b0, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
